handshake_fifo_buffer: RTL

- Elastic FIFO buffer stage placed directly downstream of handshake constant/operator units in the dataflow netlist.
- Accepts tokens on a valid/ready input channel, stores up to DEPTH of them, and replays them in order on a valid/ready output channel.
- Breaks the combinational valid path and the combinational ready path between producer and consumer, which makes it the timing and throughput buffer behind constant sources.

---
 rtl/handshake_fifo_buffer.sv | 103 ++++++++++
 1 files changed

// File: rtl/handshake_fifo_buffer.sv
// Elastic valid/ready FIFO buffer that registers both the valid and the ready paths.
// Define HANDSHAKE_FIFO_OCCUPANCY_EN to add the occupancy and occupancy_max outputs.
module handshake_fifo_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DATA_WIDTH-1:0]        ins,
  input  logic                         ins_valid,
  output logic                         ins_ready,
  output logic [DATA_WIDTH-1:0]        outs,
  output logic                         outs_valid,
  input  logic                         outs_ready
`ifdef HANDSHAKE_FIFO_OCCUPANCY_EN
  ,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_max
`endif
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  push_s, pop_s;

  // Ready and valid come only from registered state, gated off while in reset.
  assign ins_ready  = rst && (count_q != CW'(DEPTH));
  assign outs_valid = rst && (count_q != CW'(0));
  assign outs       = outs_valid ? mem_q[head_q] : {DATA_WIDTH{1'b0}};
  assign push_s     = ins_valid && ins_ready;
  assign pop_s      = outs_valid && outs_ready;

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    // Explicit compare keeps wrap correct for non-power-of-two depths.
    if (pop_s) begin
      head_d = (head_q == PW'(DEPTH - 1)) ? PW'(0) : head_q + PW'(1);
    end else begin
      head_d = head_q;
    end
    if (push_s) begin
      tail_d = (tail_q == PW'(DEPTH - 1)) ? PW'(0) : tail_q + PW'(1);
    end else begin
      tail_d = tail_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head_q  <= PW'(0);
      tail_q  <= PW'(0);
      count_q <= CW'(0);
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage is intentionally left unreset; push is already blocked during reset.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[tail_q] <= ins;
    end
  end

`ifdef HANDSHAKE_FIFO_OCCUPANCY_EN
  logic [CW-1:0] high_water_q, high_water_d;

  always_comb begin
    high_water_d = high_water_q;
    if (count_d > high_water_q) begin
      high_water_d = count_d;
    end else begin
      high_water_d = high_water_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      high_water_q <= CW'(0);
    end else begin
      high_water_q <= high_water_d;
    end
  end

  assign occupancy     = rst ? count_q : CW'(0);
  assign occupancy_max = high_water_q;
`endif

endmodule
